apb_master_bridge: RTL

- Initiator end of the APB link: converts a single-outstanding valid/ready command interface into APB SETUP/ACCESS transfers.
- Returns read data and an error flag on a valid/ready response channel.
- Sits between a core-side request source (debug or boot loader, DMA stub) and APB slaves such as the SRAM controller.
- Includes a programmable pready timeout so a dead slave cannot hang the requester.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_master_bridge.sv | 130 +++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (also used by the slave-side
// controller) and the APB response codes.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } apb_state_e;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready command at a time into an APB
// SETUP/ACCESS transfer and returns data/error on a valid/ready response.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);
  import apb_pkg::*;

  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e              r_state;
  logic [TO_WIDTH-1:0]     r_cnt;
  logic                    r_reqReady;
  logic                    r_rspValid;
  logic [DATA_WIDTH-1:0]   r_rspRdata;
  logic                    r_rspErr;
  logic                    r_psel;
  logic                    r_penable;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic                    w_toHit;

  // A dead slave is abandoned once pready has stayed low for TIMEOUT cycles.
  assign w_toHit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= RESP_OKAY;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_strb     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_reqReady <= 1'b1;
          if (req_valid && r_reqReady) begin
            r_addr     <= req_addr;
            r_write    <= req_write;
            r_wdata    <= req_wdata;
            r_strb     <= req_write ? req_strb : '0;
            r_reqReady <= 1'b0;
            r_psel     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_rspRdata <= r_write ? '0 : prdata;
            r_rspErr   <= pslverr ? RESP_SLVERR : RESP_OKAY;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end else if (w_toHit) begin
            r_rspRdata <= '0;
            r_rspErr   <= RESP_SLVERR;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + TO_WIDTH'(1);
          end
        end
        S_RESP: begin
          // Ready is re-raised only on the way into IDLE, so no command can
          // be taken in the same cycle as the response handshake.
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_addr;
  assign pwrite    = r_write;
  assign pwdata    = r_wdata;
  assign pstrb     = r_strb;

endmodule
